// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared defaults and index-width helper for the N:1 arbitrating mux
package mux_arb_pkg;
   localparam int DEF_WIDTH = 64;
   localparam int DEF_N     = 4;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mux_arb_nx1_if.sv
// mux_arb_nx1_if: N request channels in, one registered word stream out
interface mux_arb_nx1_if import mux_arb_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N
);
   localparam int IW = idx_w(N);
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [IW-1:0]      out_sel;
   logic               out_ready;
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/mux_arb_grant.sv
// mux_arb_grant: one-hot grant; round-robin after ptr with MUX_ARB_RR_EN, else lowest index wins
module mux_arb_grant import mux_arb_pkg::*; #(
   parameter int N = DEF_N,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic          en,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   int best, d;
`ifndef MUX_ARB_RR_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;
`endif
   // pick the requester with the smallest search distance from the start point
   always_comb begin
      gnt  = '0;
      idx  = '0;
      best = N;
      d    = 0;
      for (int i = 0; i < N; i++) begin
`ifdef MUX_ARB_RR_EN
         d = (i + 2 * N - 1 - int'(ptr)) % N;
`else
         d = i;
`endif
         if (en && req[i] && d < best) begin
            best = d;
            gnt  = N'(1) << i;
            idx  = IW'(i);
         end
      end
   end
endmodule

// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1: N:1 arbitrating mux into a single-entry output register (MUX_ARB_RR_EN selects round-robin)
module mux_arb_nx1 import mux_arb_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N
) (
   input logic          clk,
   input logic          rst_n,
   mux_arb_nx1_if.slave bus
);
   localparam int IW = idx_w(N);
   logic             load_en;
   logic [N-1:0]     gnt;
   logic [IW-1:0]    idx, ptr;
   logic [WIDTH-1:0] sel_data;
   assign load_en     = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = gnt;
   mux_arb_grant #(.N(N)) u_grant (
      .req (bus.in_valid),
      .en  (load_en && rst_n),
      .ptr (ptr),
      .gnt (gnt),
      .idx (idx)
   );
   // one-hot data select, independent of the grant encoding
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++)
         if (gnt[i]) sel_data = bus.in_data[i*WIDTH +: WIDTH];
   end
   // output register: refill on grant, empty on drain without grant, hold otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sel   <= '0;
      end else if (load_en) begin
         bus.out_valid <= |gnt;
         if (|gnt) begin
            bus.out_data <= sel_data;
            bus.out_sel  <= idx;
         end
      end
   end
`ifdef MUX_ARB_RR_EN
   // a grant is always an accepted transfer, so the pointer follows every grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else if (|gnt) ptr <= idx;
   end
`else
   assign ptr = '0;
`endif
endmodule

// File: tb/tb_mux_arb_nx1.sv
// tb_mux_arb_nx1: directed and random stimulus against a behavioural arbiter model
module tb_mux_arb_nx1;
   localparam int W = 64;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_tests = 0;
   int n_fail = 0;
   logic          m_valid;
   logic [W-1:0]  m_data;
   int            m_sel;
   int            m_ptr;
   mux_arb_nx1_if #(.WIDTH(W), .N(N)) bus ();
   mux_arb_nx1 #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] pack(input logic [W-1:0] a, b, c, e);
      return {e, c, b, a};
   endfunction

   function automatic int pick(input logic [N-1:0] v, input logic ordy);
      if (m_valid && !ordy) return -1;
`ifdef MUX_ARB_RR_EN
      for (int k = 1; k <= N; k++)
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
      for (int k = 0; k < N; k++)
         if (v[k]) return k;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
   endtask

   task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
      int g;
      logic [N-1:0] er;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = ordy;
      @(negedge clk);
      g  = pick(v, ordy);
      er = (g < 0) ? '0 : N'(1) << g;
      chk("in_ready", W'(bus.in_ready), W'(er));
      chk("out_valid", W'(bus.out_valid), W'(m_valid));
      chk("out_data", bus.out_data, m_data);
      chk("out_sel", W'(bus.out_sel), W'(m_sel));
      if (!m_valid || ordy) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = W'(d >> (g * W));
            m_sel   = g;
            m_ptr   = g;
         end else m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      bus.in_valid  = '1;
      bus.in_data   = '1;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", W'(bus.in_ready), '0);
      chk("rst_out_valid", W'(bus.out_valid), '0);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_out_sel", W'(bus.out_sel), '0);
      bus.in_valid = '0;
      rst_n = 1'b1;
      // single channel request
      cyc(4'b0100, pack(0, 0, 64'h2, 0), 1'b1);
      cyc(4'b0000, '0, 1'b1);
      cyc(4'b0000, '0, 1'b1);
      // all channels contending
      repeat (6) cyc(4'b1111, pack(64'h10, 64'h11, 64'h12, 64'h13), 1'b1);
      // stall holds the word, then the queued channel follows without a bubble
      cyc(4'b0001, pack(64'hAA, 0, 0, 0), 1'b1);
      repeat (3) cyc(4'b0010, pack(0, 64'hBB, 0, 0), 1'b0);
      cyc(4'b0010, pack(0, 64'hBB, 0, 0), 1'b1);
      cyc(4'b0000, '0, 1'b1);
      // drain to empty keeps the last data
      cyc(4'b0001, pack(64'h5, 0, 0, 0), 1'b1);
      cyc(4'b0000, '0, 1'b1);
      cyc(4'b0000, '0, 1'b1);
      cyc(4'b0000, '0, 1'b1);
      // random traffic
      for (int i = 0; i < 400; i++)
         cyc(N'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             ($urandom_range(0, 9) < 7));
      // reset while stalled with a held word
      cyc(4'b0001, pack(64'h77, 0, 0, 0), 1'b1);
      cyc(4'b1000, pack(0, 0, 0, 64'h33), 1'b0);
      chk("pre_rst_valid", W'(bus.out_valid), W'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", W'(bus.out_valid), '0);
      chk("mid_rst_out_sel", W'(bus.out_sel), '0);
      chk("mid_rst_out_data", bus.out_data, '0);
      chk("mid_rst_in_ready", W'(bus.in_ready), '0);
      @(posedge clk);
      #1;
      chk("held_rst_in_ready", W'(bus.in_ready), '0);
      rst_n = 1'b1;
      model_reset();
      cyc(4'b1000, pack(0, 0, 0, 64'h33), 1'b1);
      repeat (5) cyc(4'b1111, pack(64'h20, 64'h21, 64'h22, 64'h23), 1'b1);
      cyc(4'b0000, '0, 1'b1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
